// File: rtl/mcpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: opcodes, FSM states,
// ALU function codes, datapath mux selects and the opcode class type.
package mcpu_ctrl_pkg;

  localparam logic [5:0] OP_J    = 6'd1;
  localparam logic [5:0] OP_MOV  = 6'd16;
  localparam logic [5:0] OP_NOT  = 6'd17;
  localparam logic [5:0] OP_ADD  = 6'd18;
  localparam logic [5:0] OP_SUB  = 6'd19;
  localparam logic [5:0] OP_OR   = 6'd20;
  localparam logic [5:0] OP_AND  = 6'd21;
  localparam logic [5:0] OP_SLT  = 6'd23;
  localparam logic [5:0] OP_BEQ  = 6'd32;
  localparam logic [5:0] OP_BNE  = 6'd33;
  localparam logic [5:0] OP_ADDI = 6'd50;
  localparam logic [5:0] OP_SUBI = 6'd51;
  localparam logic [5:0] OP_ORI  = 6'd52;
  localparam logic [5:0] OP_ANDI = 6'd53;
  localparam logic [5:0] OP_SLTI = 6'd55;
  localparam logic [5:0] OP_LI   = 6'd57;
  localparam logic [5:0] OP_LWI  = 6'd59;
  localparam logic [5:0] OP_SWI  = 6'd60;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_REXE   = 4'd2;
  localparam logic [3:0] S_RWB    = 4'd3;
  localparam logic [3:0] S_IEXE   = 4'd4;
  localparam logic [3:0] S_IWB    = 4'd5;
  localparam logic [3:0] S_MADDR  = 4'd6;
  localparam logic [3:0] S_MRD    = 4'd7;
  localparam logic [3:0] S_LWB    = 4'd8;
  localparam logic [3:0] S_MWR    = 4'd9;
  localparam logic [3:0] S_BR     = 4'd10;
  localparam logic [3:0] S_JMP    = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;

  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;
  localparam logic [1:0] SRCB_OFF = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  typedef enum logic [2:0] {
    CL_R, CL_I, CL_LD, CL_ST, CL_BR, CL_JMP, CL_ILL
  } op_class_t;

endpackage

// File: rtl/mcpu_op_class.sv
// Combinational opcode classifier feeding the DECODE transition; zero latency,
// no handshake.
module mcpu_op_class
  import mcpu_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] OPcode,
  output op_class_t      op_class
);

  always_comb begin
    op_class = CL_ILL;
    case (OPcode)
      OP_MOV, OP_NOT, OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT:  op_class = CL_R;
      OP_ADDI, OP_SUBI, OP_ORI, OP_ANDI, OP_SLTI, OP_LI:      op_class = CL_I;
      OP_LWI:                                                 op_class = CL_LD;
      OP_SWI:                                                 op_class = CL_ST;
      OP_BEQ, OP_BNE:                                         op_class = CL_BR;
      OP_J:                                                   op_class = CL_JMP;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_fsm_controller.sv
// Moore FSM sequencing each instruction FETCH..WRITEBACK; 3-5 cycles per instruction,
// plus one cycle per mem_ready-low cycle spent in FETCH, MRD or MWR.
module multicycle_fsm_controller
  import mcpu_ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int ALUW = 4,
  parameter int STW  = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [OPW-1:0]  OPcode,
  input  logic            mem_ready,
  output logic            PCWriteCond,
  output logic            PCWrite,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            MemtoReg,
  output logic            IRWrite,
  output logic            BEQ,
  output logic            ALUSrcA,
  output logic            RegWrite,
  output logic            RegDst,
  output logic [1:0]      PCSrc,
  output logic [ALUW-1:0] ALUOP,
  output logic [1:0]      ALUSrcB,
  output logic            instr_done,
  output logic            illegal,
  output logic [STW-1:0]  state
);

  logic [STW-1:0] state_q;
  logic [STW-1:0] state_nxt;
  op_class_t      op_cls;

  mcpu_op_class #(.OPW(OPW)) u_op_class (
    .OPcode   (OPcode),
    .op_class (op_cls)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_nxt;
  end

  assign state = state_q;

  // Outputs are forced low while reset is held, even though state already reads S_FETCH.
  always_comb begin
    state_nxt   = S_FETCH;
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    BEQ         = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSrc       = PC_ALU;
    ALUOP       = '0;
    ALUSrcB     = SRCB_REG;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead   = 1'b1;
          ALUSrcB   = SRCB_ONE;
          ALUOP     = ALU_ADD;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
          state_nxt = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ALUSrcB = SRCB_OFF;
          ALUOP   = ALU_ADD;
          case (op_cls)
            CL_R:          state_nxt = S_REXE;
            CL_I:          state_nxt = S_IEXE;
            CL_LD, CL_ST:  state_nxt = S_MADDR;
            CL_BR:         state_nxt = S_BR;
            CL_JMP:        state_nxt = S_JMP;
            default:       state_nxt = S_TRAP;
          endcase
        end
        S_REXE: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = SRCB_REG;
          ALUOP     = OPcode[ALUW-1:0];
          state_nxt = S_RWB;
        end
        S_RWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_IEXE: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = SRCB_IMM;
          ALUOP     = OPcode[ALUW-1:0];
          state_nxt = S_IWB;
        end
        S_IWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MADDR: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = SRCB_IMM;
          ALUOP     = ALU_ADD;
          state_nxt = (op_cls == CL_ST) ? S_MWR : S_MRD;
        end
        S_MRD: begin
          IorD      = 1'b1;
          MemRead   = 1'b1;
          state_nxt = mem_ready ? S_LWB : S_MRD;
        end
        S_LWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MWR: begin
          IorD       = 1'b1;
          MemWrite   = 1'b1;
          instr_done = mem_ready;
          state_nxt  = mem_ready ? S_FETCH : S_MWR;
        end
        S_BR: begin
          ALUSrcA     = 1'b1;
          ALUSrcB     = SRCB_REG;
          ALUOP       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSrc       = PC_ALUOUT;
          BEQ         = (OPcode == OP_BEQ);
          instr_done  = 1'b1;
        end
        S_JMP: begin
          PCWrite    = 1'b1;
          PCSrc      = PC_JUMP;
          instr_done = 1'b1;
        end
        S_TRAP: begin
          illegal   = 1'b1;
          state_nxt = S_TRAP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_fsm_controller.sv
// Directed bench: expected per-cycle control vectors are queued as each cycle is
// driven and popped for comparison once the outputs have settled.
module tb_multicycle_fsm_controller;
  import mcpu_ctrl_pkg::*;

  typedef struct packed {
    logic       pcwc, pcw, iord, mrd, mwr, m2r, irw, beq, srca, regw, regdst;
    logic [1:0] pcsrc;
    logic [3:0] aluop;
    logic [1:0] srcb;
    logic       done, ill;
    logic [3:0] st;
  } obs_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ready = 1'b0;
  logic [5:0] OPcode = 6'd0;
  logic       PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       BEQ, ALUSrcA, RegWrite, RegDst, instr_done, illegal;
  logic [1:0] PCSrc, ALUSrcB;
  logic [3:0] ALUOP, state;

  obs_t obs;
  obs_t expq[$];
  int   checks = 0;
  int   errors = 0;

  multicycle_fsm_controller dut (
    .clock(clock), .reset(reset), .OPcode(OPcode), .mem_ready(mem_ready),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .BEQ(BEQ),
    .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst), .PCSrc(PCSrc),
    .ALUOP(ALUOP), .ALUSrcB(ALUSrcB), .instr_done(instr_done), .illegal(illegal),
    .state(state)
  );

  always #5 clock = ~clock;

  assign obs = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, BEQ,
                ALUSrcA, RegWrite, RegDst, PCSrc, ALUOP, ALUSrcB, instr_done, illegal, state};

  // Reference control table for the cycle spent in state st.
  function automatic obs_t model(input logic [3:0] st, input logic [5:0] op,
                                 input logic mr, input logic rst);
    obs_t e;
    e = '0;
    if (rst) return e;
    e.st = st;
    case (st)
      S_FETCH:  begin e.mrd = 1; e.srcb = 2'd1; e.aluop = 4'd2; e.irw = mr; e.pcw = mr; end
      S_DECODE: begin e.srcb = 2'd3; e.aluop = 4'd2; end
      S_REXE:   begin e.srca = 1; e.srcb = 2'd0; e.aluop = op[3:0]; end
      S_RWB:    begin e.regdst = 1; e.regw = 1; e.done = 1; end
      S_IEXE:   begin e.srca = 1; e.srcb = 2'd2; e.aluop = op[3:0]; end
      S_IWB:    begin e.regw = 1; e.done = 1; end
      S_MADDR:  begin e.srca = 1; e.srcb = 2'd2; e.aluop = 4'd2; end
      S_MRD:    begin e.iord = 1; e.mrd = 1; end
      S_LWB:    begin e.regw = 1; e.m2r = 1; e.done = 1; end
      S_MWR:    begin e.iord = 1; e.mwr = 1; e.done = mr; end
      S_BR:     begin e.srca = 1; e.aluop = 4'd3; e.pcwc = 1; e.pcsrc = 2'd1;
                      e.beq = (op == 6'd32); e.done = 1; end
      S_JMP:    begin e.pcw = 1; e.pcsrc = 2'd2; e.done = 1; end
      S_TRAP:   begin e.ill = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // One clock cycle: entered and left at a falling edge.
  task automatic cyc(input logic [3:0] st, input logic mr);
    obs_t e;
    obs_t o;
    mem_ready = mr;
    expq.push_back(model(st, OPcode, mr, reset));
    #1;
    o = obs;
    e = expq.pop_front();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL ctrl op=%0d st=%0d observed=%h expected=%h", OPcode, st, o, e);
    end
    checks++;
    assert (((o.pcw & o.pcwc) === 1'b0) && ((o.mrd & o.mwr) === 1'b0)) else begin
      errors++;
      $error("FAIL excl observed pcw,pcwc,mrd,mwr=%b%b%b%b expected no pair high",
             o.pcw, o.pcwc, o.mrd, o.mwr);
    end
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clock);
    repeat (3) cyc(S_FETCH, 1'b1);
    reset = 1'b0;

    OPcode = 6'd18;   // add
    cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_REXE, 1'b1); cyc(S_RWB, 1'b1);

    OPcode = 6'd59;   // lwi, memory stalls two cycles
    cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_MADDR, 1'b1);
    cyc(S_MRD, 1'b0); cyc(S_MRD, 1'b0); cyc(S_MRD, 1'b1); cyc(S_LWB, 1'b1);

    OPcode = 6'd33;   // bne
    cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_BR, 1'b1);
    OPcode = 6'd32;   // beq
    cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_BR, 1'b1);

    OPcode = 6'd60;   // swi with a stalled fetch and one write wait
    cyc(S_FETCH, 1'b0); cyc(S_FETCH, 1'b0); cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1);
    cyc(S_MADDR, 1'b1); cyc(S_MWR, 1'b0); cyc(S_MWR, 1'b1);

    OPcode = 6'd57;   // li
    cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_IEXE, 1'b1); cyc(S_IWB, 1'b1);

    OPcode = 6'd1;    // j
    cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_JMP, 1'b1);

    OPcode = 6'd60;   // swi aborted by reset while waiting in MWR
    cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_MADDR, 1'b1); cyc(S_MWR, 1'b0);
    reset = 1'b1;
    cyc(S_FETCH, 1'b1);
    reset = 1'b0;
    cyc(S_FETCH, 1'b0);

    OPcode = 6'd5;    // undefined opcode traps until reset
    cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1);
    repeat (10) cyc(S_TRAP, 1'b1);
    reset = 1'b1;
    cyc(S_FETCH, 1'b1);
    reset = 1'b0;
    cyc(S_FETCH, 1'b1);
    cyc(S_DECODE, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
